// File: rtl/sm83_pkg.sv
`default_nettype none
// ============================================================================
// sm83_pkg : shared ctl_op / ex_state encodings and microcode entry format
// Rev 1.0
// ============================================================================
package sm83_pkg;

  localparam int UC_MAX_STEPS = 8;
  localparam int UC_IDX_W     = 3;
  localparam int DISPATCH_LEN = 5;

  localparam logic [UC_IDX_W-1:0] COND_NONE = '1;

  typedef enum logic [5:0] {
    CTL_NOP        = 6'd0,
    CTL_LD_R16_D16 = 6'd1,
    CTL_LD_R8_R8   = 6'd2,
    CTL_JP_COND    = 6'd3,
    CTL_CALL_A16   = 6'd4,
    CTL_RET_COND   = 6'd5,
    CTL_HALT       = 6'd6
  } ctl_op_t;

  typedef enum logic [4:0] {
    EX_IDLE       = 5'd0,
    EX_MEM_TO_Z   = 5'd1,
    EX_MEM_TO_W   = 5'd2,
    EX_WZ_TO_R16  = 5'd3,
    EX_WZ_TO_PC   = 5'd4,
    EX_R8_TO_R8   = 5'd5,
    EX_DEC_R16    = 5'd6,
    EX_PCH_TO_MEM = 5'd7,
    EX_PCL_TO_MEM = 5'd8,
    EX_VEC_TO_PC  = 5'd9,
    EX_HALT       = 5'd10
  } ex_state_t;

  typedef struct packed {
    ex_state_t [UC_MAX_STEPS-1:0] seq;
    logic [UC_IDX_W-1:0]          last_t;
    logic [UC_IDX_W-1:0]          last_nt;
    logic [UC_IDX_W-1:0]          cond_idx;
  } ucode_entry_t;

  // Out-of-table indices read as EX_IDLE.
  function automatic ex_state_t uc_step_state(ucode_entry_t e, int idx);
    ex_state_t s;
    s = EX_IDLE;
    for (int i = 0; i < UC_MAX_STEPS; i++) begin
      if (i == idx) s = e.seq[UC_IDX_W'(i)];
    end
    return s;
  endfunction

  function automatic ex_state_t uc_dispatch_state(int idx);
    ex_state_t s;
    case (idx)
      1:       s = EX_DEC_R16;
      2:       s = EX_PCH_TO_MEM;
      3:       s = EX_PCL_TO_MEM;
      4:       s = EX_VEC_TO_PC;
      default: s = EX_IDLE;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucode_rom.sv
`default_nettype none
// ============================================================================
// ucode_rom : combinational ctl_op -> microstep sequence table
// Rev 1.0
// ============================================================================
module ucode_rom
  import sm83_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] ctl_op,
  output ucode_entry_t    entry
);

  always_comb begin
    entry          = '0;
    entry.cond_idx = COND_NONE;
    case (ctl_op)
      CTL_LD_R16_D16: begin
        entry.seq[0]  = EX_MEM_TO_Z;
        entry.seq[1]  = EX_MEM_TO_W;
        entry.seq[2]  = EX_WZ_TO_R16;
        entry.last_t  = 3'd2;
        entry.last_nt = 3'd2;
      end
      CTL_LD_R8_R8: begin
        entry.seq[0] = EX_R8_TO_R8;
      end
      // Not-taken path ends on idx 2; PC load there is gated downstream by taken.
      CTL_JP_COND: begin
        entry.seq[0]   = EX_MEM_TO_Z;
        entry.seq[1]   = EX_MEM_TO_W;
        entry.seq[2]   = EX_WZ_TO_PC;
        entry.seq[3]   = EX_IDLE;
        entry.last_t   = 3'd3;
        entry.last_nt  = 3'd2;
        entry.cond_idx = 3'd1;
      end
      CTL_CALL_A16: begin
        entry.seq[0]  = EX_MEM_TO_Z;
        entry.seq[1]  = EX_MEM_TO_W;
        entry.seq[2]  = EX_DEC_R16;
        entry.seq[3]  = EX_PCH_TO_MEM;
        entry.seq[4]  = EX_PCL_TO_MEM;
        entry.seq[5]  = EX_WZ_TO_PC;
        entry.last_t  = 3'd5;
        entry.last_nt = 3'd5;
      end
      CTL_RET_COND: begin
        entry.seq[0]   = EX_IDLE;
        entry.seq[1]   = EX_MEM_TO_Z;
        entry.seq[2]   = EX_MEM_TO_W;
        entry.seq[3]   = EX_WZ_TO_PC;
        entry.seq[4]   = EX_IDLE;
        entry.last_t   = 3'd4;
        entry.last_nt  = 3'd1;
        entry.cond_idx = 3'd0;
      end
      CTL_HALT: begin
        entry.seq[0] = EX_HALT;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ucode_sequencer.sv
`default_nettype none
// ============================================================================
// ucode_sequencer : table-driven execute sequencer with stall, conditional
// truncation, interrupt dispatch (UCODE_SEQ_IRQ_EN) and HALT wake.  Rev 1.0
// ============================================================================
module ucode_sequencer
  import sm83_pkg::*;
#(
  parameter int MAX_STEPS = 8,
  parameter int IDX_W     = $clog2(MAX_STEPS),
  parameter int OP_W      = 6,
  parameter int ST_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  ctl_op,
  input  logic             stall,
  input  logic             cond_true,
  input  logic             irq_pending,
  input  logic             ime,
  output logic [ST_W-1:0]  step_state,
  output logic [IDX_W-1:0] step_idx,
  output logic             step_en,
  output logic             fetch,
  output logic             taken,
  output logic             dispatch,
  output logic             irq_ack,
  output logic             halt
);

  // MODE_FETCH is the lone fetch cycle that follows a dispatch or a HALT wake.
  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_DISP  = 2'd1;
  localparam logic [1:0] MODE_HALT  = 2'd2;
  localparam logic [1:0] MODE_FETCH = 2'd3;

  logic [1:0]       mode_q, mode_d;
  logic [IDX_W-1:0] step_idx_q, step_idx_d;
  logic             taken_q, taken_d;

  ucode_entry_t        w_entry;
  ex_state_t           w_run_state;
  logic [UC_IDX_W-1:0] w_eff_last;
  logic                w_last, w_cond_step, w_disp_last;
  logic                w_irq_take, w_wake_disp;

  ucode_rom #(.OP_W(OP_W)) u_rom (
    .ctl_op (ctl_op),
    .entry  (w_entry)
  );

`ifdef UCODE_SEQ_IRQ_EN
  assign w_irq_take  = ime & irq_pending;
  assign w_wake_disp = ime;
`else
  assign w_irq_take  = 1'b0;
  assign w_wake_disp = 1'b0;
  logic w_unused_ime;
  assign w_unused_ime = ime;
`endif

  always_comb begin
    w_eff_last  = taken_q ? w_entry.last_t : w_entry.last_nt;
    w_last      = (int'(step_idx_q) >= int'(w_eff_last)) || (int'(step_idx_q) >= MAX_STEPS);
    w_cond_step = (w_entry.cond_idx != COND_NONE) &&
                  (int'(step_idx_q) == int'(w_entry.cond_idx));
    w_disp_last = int'(step_idx_q) >= DISPATCH_LEN - 1;
    w_run_state = (int'(step_idx_q) >= MAX_STEPS) ? EX_IDLE
                                                  : uc_step_state(w_entry, int'(step_idx_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_RUN;
      step_idx_q <= '0;
      taken_q    <= 1'b1;
    end else begin
      mode_q     <= mode_d;
      step_idx_q <= step_idx_d;
      taken_q    <= taken_d;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    step_idx_d = step_idx_q;
    taken_d    = taken_q;
    if (!stall) begin
      case (mode_q)
        MODE_RUN: begin
          // HALT's own step neither fetches nor dispatches; the wake path does.
          if (w_run_state == EX_HALT) begin
            mode_d = MODE_HALT;
          end else if (w_last) begin
            step_idx_d = '0;
            taken_d    = 1'b1;
            if (w_irq_take) mode_d = MODE_DISP;
          end else begin
            step_idx_d = step_idx_q + IDX_W'(1);
            if (w_cond_step) taken_d = cond_true;
          end
        end
        MODE_DISP: begin
          if (w_disp_last) begin
            step_idx_d = '0;
            mode_d     = MODE_FETCH;
          end else begin
            step_idx_d = step_idx_q + IDX_W'(1);
          end
        end
        MODE_HALT: begin
          if (irq_pending) begin
            step_idx_d = '0;
            mode_d     = w_wake_disp ? MODE_DISP : MODE_FETCH;
          end
        end
        default: begin
          step_idx_d = '0;
          taken_d    = 1'b1;
          mode_d     = MODE_RUN;
        end
      endcase
    end
  end

  always_comb begin
    step_en    = !stall;
    step_idx   = step_idx_q;
    taken      = taken_q;
    halt       = (mode_q == MODE_HALT);
    fetch      = 1'b0;
    step_state = ST_W'(EX_IDLE);
    case (mode_q)
      MODE_RUN: begin
        step_state = ST_W'(w_run_state);
        fetch      = w_last && !w_irq_take && (w_run_state != EX_HALT);
      end
      MODE_DISP:  step_state = ST_W'(uc_dispatch_state(int'(step_idx_q)));
      MODE_FETCH: fetch = 1'b1;
      default: ;
    endcase
  end

`ifdef UCODE_SEQ_IRQ_EN
  assign dispatch = (mode_q == MODE_DISP);
  assign irq_ack  = (mode_q == MODE_DISP) && w_disp_last;
`else
  assign dispatch = 1'b0;
  assign irq_ack  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ucode_sequencer : directed + randomized bench with a cycle-level model
// Rev 1.0
// ============================================================================
module tb_ucode_sequencer;
  import sm83_pkg::*;

`ifdef UCODE_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] ctl_op = 6'd0;
  logic       stall = 1'b0, cond_true = 1'b0, irq_pending = 1'b0, ime = 1'b0;
  logic [4:0] step_state;
  logic [2:0] step_idx;
  logic       step_en, fetch, taken, dispatch, irq_ack, halt;

  ucode_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctl_op      (ctl_op),
    .stall       (stall),
    .cond_true   (cond_true),
    .irq_pending (irq_pending),
    .ime         (ime),
    .step_state  (step_state),
    .step_idx    (step_idx),
    .step_en     (step_en),
    .fetch       (fetch),
    .taken       (taken),
    .dispatch    (dispatch),
    .irq_ack     (irq_ack),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: instruction lengths in cycles (taken / not taken) and step lists.
  int        len_t[64], len_nt[64], cond_at[64];
  ex_state_t seq_tab[64][8];
  ex_state_t disp_tab[5];
  logic [5:0] ops[8];

  bit m_halted, m_disp, m_refetch, m_taken, m_boundary;
  int m_idx;

  task automatic check_val(string tag, int obs, int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic init_tables();
    for (int o = 0; o < 64; o++) begin
      len_t[o] = 1; len_nt[o] = 1; cond_at[o] = -1;
      for (int i = 0; i < 8; i++) seq_tab[o][i] = EX_IDLE;
    end
    seq_tab[CTL_LD_R16_D16][0] = EX_MEM_TO_Z;  seq_tab[CTL_LD_R16_D16][1] = EX_MEM_TO_W;
    seq_tab[CTL_LD_R16_D16][2] = EX_WZ_TO_R16;
    len_t[CTL_LD_R16_D16] = 3; len_nt[CTL_LD_R16_D16] = 3;
    seq_tab[CTL_LD_R8_R8][0] = EX_R8_TO_R8;
    seq_tab[CTL_JP_COND][0] = EX_MEM_TO_Z; seq_tab[CTL_JP_COND][1] = EX_MEM_TO_W;
    seq_tab[CTL_JP_COND][2] = EX_WZ_TO_PC;
    len_t[CTL_JP_COND] = 4; len_nt[CTL_JP_COND] = 3; cond_at[CTL_JP_COND] = 1;
    seq_tab[CTL_CALL_A16][0] = EX_MEM_TO_Z;   seq_tab[CTL_CALL_A16][1] = EX_MEM_TO_W;
    seq_tab[CTL_CALL_A16][2] = EX_DEC_R16;    seq_tab[CTL_CALL_A16][3] = EX_PCH_TO_MEM;
    seq_tab[CTL_CALL_A16][4] = EX_PCL_TO_MEM; seq_tab[CTL_CALL_A16][5] = EX_WZ_TO_PC;
    len_t[CTL_CALL_A16] = 6; len_nt[CTL_CALL_A16] = 6;
    seq_tab[CTL_RET_COND][1] = EX_MEM_TO_Z; seq_tab[CTL_RET_COND][2] = EX_MEM_TO_W;
    seq_tab[CTL_RET_COND][3] = EX_WZ_TO_PC;
    len_t[CTL_RET_COND] = 5; len_nt[CTL_RET_COND] = 2; cond_at[CTL_RET_COND] = 0;
    seq_tab[CTL_HALT][0] = EX_HALT;
    disp_tab = '{EX_IDLE, EX_DEC_R16, EX_PCH_TO_MEM, EX_PCL_TO_MEM, EX_VEC_TO_PC};
    ops = '{CTL_NOP, CTL_LD_R16_D16, CTL_LD_R8_R8, CTL_JP_COND,
            CTL_CALL_A16, CTL_RET_COND, CTL_HALT, 6'd63};
  endtask

  task automatic model_reset();
    m_halted = 0; m_disp = 0; m_refetch = 0; m_taken = 1; m_idx = 0; m_boundary = 1;
  endtask

  function automatic bit m_irq_take();
    return IRQ_EN && ime && irq_pending;
  endfunction

  function automatic bit m_last();
    int op = int'(ctl_op);
    return (m_idx + 1) >= (m_taken ? len_t[op] : len_nt[op]);
  endfunction

  function automatic ex_state_t m_state();
    if (m_halted || m_refetch) return EX_IDLE;
    if (m_disp) return disp_tab[m_idx];
    return seq_tab[int'(ctl_op)][m_idx];
  endfunction

  function automatic bit m_fetch();
    if (m_refetch) return 1'b1;
    if (m_halted || m_disp) return 1'b0;
    return m_last() && !m_irq_take() && (m_state() != EX_HALT);
  endfunction

  task automatic check_all();
    check_val("step_state", int'(step_state), int'(m_state()));
    check_val("step_idx",   int'(step_idx),   m_idx);
    check_val("step_en",    int'(step_en),    int'(!stall));
    check_val("fetch",      int'(fetch),      int'(m_fetch()));
    check_val("taken",      int'(taken),      int'(m_taken));
    check_val("dispatch",   int'(dispatch),   int'(m_disp));
    check_val("irq_ack",    int'(irq_ack),    int'(m_disp && m_idx == 4));
    check_val("halt",       int'(halt),       int'(m_halted));
  endtask

  task automatic model_step();
    bit was_fetch;
    int op;
    if (stall) begin
      m_boundary = 0;
      return;
    end
    was_fetch = m_fetch();
    op = int'(ctl_op);
    if (m_refetch) begin
      m_refetch = 0; m_idx = 0; m_taken = 1;
    end else if (m_halted) begin
      if (irq_pending) begin
        m_halted = 0;
        if (IRQ_EN && ime) m_disp = 1; else m_refetch = 1;
      end
    end else if (m_disp) begin
      if (m_idx == 4) begin m_disp = 0; m_refetch = 1; m_idx = 0; end
      else m_idx++;
    end else if (m_state() == EX_HALT) begin
      m_halted = 1;
    end else if (m_last()) begin
      if (m_irq_take()) m_disp = 1;
      m_idx = 0; m_taken = 1;
    end else begin
      if (m_idx == cond_at[op]) m_taken = cond_true;
      m_idx++;
    end
    m_boundary = was_fetch;
  endtask

  task automatic sample(input bit s, input bit c, input bit irq, input bit ie);
    stall = s; cond_true = c; irq_pending = irq; ime = ie;
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Runs one instruction from its first step; stalls stall_n cycles at stall_idx.
  task automatic run_insn(input logic [5:0] op, input bit c, input int stall_idx,
                          input int stall_n, output int cyc, output int fidx);
    int  stalls;
    bit  done, s;
    stalls = 0; done = 0; cyc = 0; fidx = -1;
    ctl_op = op;
    while (!done && cyc < 30) begin
      s = (m_idx == stall_idx) && (stalls < stall_n);
      sample(s, c, 1'b0, 1'b0);
      if (s) stalls++;
      if (m_fetch() && !s) begin
        done = 1;
        fidx = int'(step_idx);
      end
      cyc++;
      advance();
    end
    check_val("insn_completed", int'(done), 1);
  endtask

  initial begin
    int cyc, fidx;
    init_tables();
    model_reset();

    rst_n = 1'b0; ctl_op = CTL_LD_R16_D16;
    sample(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("reset_state", int'(step_state), int'(EX_MEM_TO_Z));
    @(posedge clk); #1; rst_n = 1'b1;

    run_insn(CTL_LD_R16_D16, 1'b0, -1, 0, cyc, fidx);
    check_val("ld16_cycles", cyc, 3);
    check_val("ld16_fetch_idx", fidx, 2);
    run_insn(CTL_JP_COND, 1'b0, -1, 0, cyc, fidx);
    check_val("jp_nt_cycles", cyc, 3);
    check_val("jp_nt_fetch_idx", fidx, 2);
    run_insn(CTL_JP_COND, 1'b1, -1, 0, cyc, fidx);
    check_val("jp_t_cycles", cyc, 4);
    check_val("jp_t_fetch_idx", fidx, 3);
    run_insn(CTL_CALL_A16, 1'b0, 3, 2, cyc, fidx);
    check_val("call_stall_cycles", cyc, 8);
    check_val("call_fetch_idx", fidx, 5);
    run_insn(CTL_RET_COND, 1'b0, -1, 0, cyc, fidx);
    check_val("ret_nt_cycles", cyc, 2);

    // Interrupt entry at the last step of a one-step op.
    ctl_op = CTL_LD_R8_R8;
    sample(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("irq_entry_fetch", int'(fetch), int'(!IRQ_EN));
    advance();
    for (int k = 0; k < 5; k++) begin
      sample(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("disp_active", int'(dispatch), int'(IRQ_EN));
      check_val("disp_ack", int'(irq_ack), int'(IRQ_EN && k == 4));
      advance();
    end
    sample(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("post_disp_fetch", int'(fetch), 1);
    check_val("post_disp_flag", int'(dispatch), 0);
    advance();

    // HALT, ime=0; a stalled irq must not wake it.
    ctl_op = CTL_HALT;
    sample(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("halt_step_fetch", int'(fetch), 0);
    advance();
    for (int k = 0; k < 10; k++) begin
      sample(k == 5, 1'b0, k == 5, 1'b0);
      check_val("halted", int'(halt), 1);
      check_val("halted_fetch", int'(fetch), 0);
      advance();
    end
    sample(1'b0, 1'b0, 1'b1, 1'b0);
    advance();
    sample(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("wake_halt", int'(halt), 0);
    check_val("wake_fetch", int'(fetch), 1);
    check_val("wake_disp", int'(dispatch), 0);
    advance();

    // Asynchronous reset at idx 4 of CALL.
    ctl_op = CTL_CALL_A16;
    for (int k = 0; k < 4; k++) begin sample(1'b0, 1'b0, 1'b0, 1'b0); advance(); end
    sample(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("pre_reset_idx", int'(step_idx), 4);
    rst_n = 1'b0; #1;
    check_val("arst_idx", int'(step_idx), 0);
    check_val("arst_taken", int'(taken), 1);
    check_val("arst_halt", int'(halt), 0);
    check_val("arst_disp", int'(dispatch), 0);
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;

    // Asynchronous reset while halted.
    ctl_op = CTL_HALT;
    sample(1'b0, 1'b0, 1'b0, 1'b0); advance();
    sample(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; #1;
    check_val("arst_from_halt", int'(halt), 0);
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      if (m_boundary) ctl_op = ops[$urandom_range(0, 7)];
      sample($urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Parametrised, table-driven execute sequencer for the sm83 core; the successor to the fixed 6-step control sequencer.
- Each decoded ctl_op selects a microstep sequence from a combinational ROM. The sequence depth is set by a parameter.
- Adds four things the fixed sequencer lacks: memory stall, a generic conditional-truncation point per op, interrupt dispatch between instructions, and HALT wake-up.
- Sits between the decoder and the datapath strobe decode. Downstream logic turns `step_state` into datapath strobes.

Parameters:
- MAX_STEPS, 8, maximum microsteps per op (power of 2 not required)
- IDX_W, $clog2(MAX_STEPS), step index width
- OP_W, 6, ctl_op_t width
- ST_W, 5, ex_state_t width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- ctl_op  in  OP_W  decoded op of the current instruction, stable while it executes
- stall  in  1  memory not ready; freeze the sequencer
- cond_true  in  1  flag-condition result, sampled at the op's cond step
- irq_pending  in  1  (IE & IF) != 0
- ime  in  1  interrupt master enable
- step_state  out  ST_W  current ex_state_t
- step_idx  out  IDX_W  current step index
- step_en  out  1  = !stall; downstream qualifies all strobes with it
- fetch  out  1  last step with no dispatch: mem_to_ir + inc_pc
- taken  out  1  conditional result latched for this instruction
- dispatch  out  1  executing the interrupt dispatch sequence
- irq_ack  out  1  one-cycle pulse on the final dispatch step (clear IF bit, clear IME)
- halt  out  1  core halted

Behaviour:
- Reset: step_idx=0, taken=1, dispatch=0, irq_ack=0, halt=0, step_state = ROM(ctl_op)[0].
- The ROM returns, per op:
  - seq[MAX_STEPS]
  - last_t: last index if taken
  - last_nt: last index if not taken
  - cond_idx: conditional step index, or all-ones for none
- Required ROM invariant: last_nt >= cond_idx+1 and last_nt <= last_t. Ops without a cond step have last_nt = last_t.
- Effective last index: eff_last = taken ? last_t : last_nt. Any index >= eff_last counts as the last step.
- When stall=1, every register holds; outputs are unchanged except step_en=0.
- Normal advance (stall=0):
  - Not last: step_idx+1.
  - Last: step_idx returns to 0 and taken returns to 1.
- At step_idx == cond_idx, taken <= cond_true. The latched value is used from the next cycle onward.
- Interrupt entry, on the last step of an instruction:
  - If ime && irq_pending: fetch=0, dispatch<=1, step_idx<=0. The dispatch ROM is then used: EX_IDLE, EX_DEC_R16, EX_PCH_TO_MEM, EX_PCL_TO_MEM, EX_VEC_TO_PC, 5 steps total.
  - Otherwise fetch=1.
- irq_ack is asserted in the EX_VEC_TO_PC cycle. At the end of that cycle dispatch<=0 and the next step is a normal fetch.
- Interrupts are never taken mid-instruction or mid-dispatch.
- HALT op: halt<=1 when EX_HALT executes.
  - While halted: step_idx holds, step_state=EX_IDLE, fetch=0.
  - irq_pending clears halt on the next edge, regardless of ime.
  - If ime=1 the core then enters dispatch; if ime=0 it resumes with a fetch.
- Stall and irq_pending in the same cycle: the stall wins and the decision is deferred.
- Indices at or beyond MAX_STEPS decode to EX_IDLE and are treated as last.
- Reset mid-sequence aborts immediately to the reset state.

Optional Feature:
- Macro: UCODE_SEQ_IRQ_EN.
- Defined: dispatch sequence, irq_ack, and HALT wake with dispatch as described above.
- Undefined:
  - dispatch and irq_ack are tied 0.
  - The last step always fetches.
  - HALT exits on irq_pending into a plain fetch.
  - ime is ignored.

Decomposition:
- sm83_pkg gains:
  - ex_state_t entries EX_VEC_TO_PC and EX_DEC_R16 (if not already present)
  - ucode_entry_t struct {seq, last_t, last_nt, cond_idx}
  - localparam COND_NONE
  - DISPATCH_LEN=5
- Sub-module ucode_rom: a purely combinational ctl_op -> ucode_entry_t case table. This keeps sequence data separate from the counter and FSM logic.

Test Plan:
- CTL_LD_R16_D16, no stall -> step_idx 0,1,2 with states MEM_TO_Z, MEM_TO_W, WZ_TO_R16; fetch=1 at idx 2; idx=0 next cycle.
- CTL_JP_COND with cond_true=0 at idx 1 -> taken=0; fetch at idx 2; total 3 cycles. With cond_true=1 -> 4 cycles, fetch at idx 3.
- CTL_CALL_A16 with stall=1 for 2 cycles at idx 3 -> idx held at 3, step_en=0; completes at idx 5 after 8 cycles total.
- ime=1, irq_pending=1 at the last step of CTL_LD_R8_R8 -> fetch=0, dispatch=1 for 5 cycles, irq_ack pulses once in cycle 5, then fetch.
- CTL_HALT with ime=0, irq_pending raised 10 cycles later -> halt falls next edge, fetch follows, dispatch stays 0.
- rst_n asserted at idx 4 of CTL_CALL_A16 -> idx=0, taken=1, halt=0, dispatch=0 asynchronously.
